// File: rtl/mem_arb_pkg.sv
// Purpose: shared types and defaults for the fetch / load-store memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_t;

  // Lost arbitrations a waiting fetch tolerates before it is forced through.
  localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Purpose: arbitrates a fetch read port and a load/store port onto one memory port.
// Latency: request -> mem_req_o same cycle; response routed combinationally on mem_rvalid_i.
// Backpressure: one outstanding transaction; requests are held off (no grant) in WAIT_RSP.
//
// Ports:
//   clk_i, rst_i (async, active low)
//   if_*  : fetch request (req/addr), grant, read response (rvalid/rdata)
//   ls_*  : load/store request (req/we/be/addr/wdata), grant, response / write ack
//   flush_i : branch-taken flush, discards the in-flight fetch response
//   mem_* : shared memory request, grant and response
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [3:0]  ls_be_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t       state;
  arb_owner_t       owner;
  logic [CNT_W-1:0] starve_cnt;
  logic             drop_flag;

  logic idle;
  logic busy;
  logic sel_if;
  logic fetch_own;
  logic ls_own;

  // Outputs are qualified with rst_i so every output is 0 while reset is held,
  // including the combinational request path.
  assign idle      = rst_i && (state == IDLE);
  assign busy      = rst_i && (state == WAIT_RSP);
  assign sel_if    = if_req_i && (!ls_req_i || (starve_cnt == CNT_MAX));
  assign fetch_own = busy && (owner == OWN_IF);
  assign ls_own    = busy && (owner == OWN_LS);

  assign mem_req_o = idle && (if_req_i || ls_req_i);
  assign if_gnt_o  = mem_req_o && mem_gnt_i && sel_if;
  assign ls_gnt_o  = mem_req_o && mem_gnt_i && !sel_if;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (mem_req_o) begin
      if (sel_if) begin
        mem_be_o   = 4'hF;
        mem_addr_o = if_addr_i;
      end else begin
        mem_we_o    = ls_we_i;
        mem_be_o    = ls_be_i;
        mem_addr_o  = ls_addr_i;
        mem_wdata_o = ls_wdata_i;
      end
    end
  end

  // A flushed fetch response is still consumed (it closes the transaction)
  // but never presented; a flush in the response cycle itself also hides it.
  assign if_rvalid_o = fetch_own && mem_rvalid_i && !drop_flag && !flush_i;
  assign ls_rvalid_o = ls_own && mem_rvalid_i;
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : 32'h0;
  assign ls_rdata_o  = ls_rvalid_o ? mem_rdata_i : 32'h0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      starve_cnt <= '0;
      drop_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (if_gnt_o || ls_gnt_o) begin
            state <= WAIT_RSP;
            owner <= if_gnt_o ? OWN_IF : OWN_LS;
          end
        end
        WAIT_RSP: begin
          if (mem_rvalid_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Counts arbitrations the fetch port lost while it was asking.
      if (if_gnt_o) begin
        starve_cnt <= '0;
      end else if (if_req_i && ls_gnt_o && (starve_cnt != CNT_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      if (fetch_own && mem_rvalid_i) begin
        drop_flag <= 1'b0;
      end else if (flush_i && (fetch_own || if_gnt_o)) begin
        drop_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i, ls_we_i;
  logic [3:0]  ls_be_i;
  logic [31:0] ls_addr_i, ls_wdata_i;
  logic        ls_gnt_o, ls_rvalid_o;
  logic [31:0] ls_rdata_o;
  logic        flush_i;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i),
    .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
    .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .flush_i(flush_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // in = {if_req, ls_req, ls_we, mem_gnt, mem_rvalid, flush}
  // ex = {mem_req, if_gnt, ls_gnt, if_rvalid, ls_rvalid, ls_selected}
  typedef struct {
    logic [5:0]  in;
    logic [31:0] rd;
    logic [5:0]  ex;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(input logic [5:0] in, input logic [31:0] rd, input logic [5:0] ex);
    vec_t v;
    v.in = in;
    v.rd = rd;
    v.ex = ex;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] in, input logic [31:0] rd);
    if_req_i     = in[5];
    ls_req_i     = in[4];
    ls_we_i      = in[3];
    mem_gnt_i    = in[2];
    mem_rvalid_i = in[1];
    flush_i      = in[0];
    mem_rdata_i  = rd;
  endtask

  task automatic default_fields();
    if_addr_i  = 32'h0000_0100;
    ls_addr_i  = 32'h0000_2000;
    ls_be_i    = 4'b0011;
    ls_wdata_i = 32'hDEAD_BEEF;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " mem_req"}, 32'(mem_req_o), 32'h0);
    chk({tag, " grants"}, 32'({if_gnt_o, ls_gnt_o}), 32'h0);
    chk({tag, " rvalids"}, 32'({if_rvalid_o, ls_rvalid_o}), 32'h0);
    chk({tag, " rdata"}, if_rdata_o | ls_rdata_o, 32'h0);
    chk({tag, " mem_fields"}, mem_addr_o | mem_wdata_o | 32'({mem_we_o, mem_be_o}), 32'h0);
  endtask

  // Holds reset across a posedge with both requesters and the memory active.
  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    default_fields();
    drive(6'b111111, 32'hFFFF_FFFF);
    #1;
    chk_all_zero("reset");
    @(negedge clk_i);
    drive(6'b000000, 32'h0);
    rst_i = 1'b1;
  endtask

  initial begin
    rst_i = 1'b0;
    default_fields();
    drive(6'b000000, 32'h0);

    tbl[0]  = mk(6'b100100, 32'h0,  6'b110000); // fetch 0x100 granted
    tbl[1]  = mk(6'b100000, 32'h0,  6'b000000); // waiting
    tbl[2]  = mk(6'b100010, 32'h13, 6'b000100); // fetch data returned
    tbl[3]  = mk(6'b000000, 32'h0,  6'b000000); // bubble
    tbl[4]  = mk(6'b011100, 32'h0,  6'b101001); // ls write granted
    tbl[5]  = mk(6'b011000, 32'h0,  6'b000000); // held off
    tbl[6]  = mk(6'b011010, 32'h5A, 6'b000010); // write ack
    tbl[7]  = mk(6'b000010, 32'h77, 6'b000000); // spurious rvalid in IDLE
    tbl[8]  = mk(6'b110000, 32'h0,  6'b100001); // both, no mem grant
    tbl[9]  = mk(6'b110000, 32'h0,  6'b100001);
    tbl[10] = mk(6'b110000, 32'h0,  6'b100001);
    tbl[11] = mk(6'b110100, 32'h0,  6'b101001); // ls read wins
    tbl[12] = mk(6'b110000, 32'h0,  6'b000000);
    tbl[13] = mk(6'b110010, 32'h99, 6'b000010);

    // ---------------- table-driven vectors ----------------
    do_reset();
    for (int i = 0; i < 14; i++) begin
      logic exp_ls;
      drive(tbl[i].in, tbl[i].rd);
      #1;
      exp_ls = tbl[i].ex[0];
      chk($sformatf("v%0d mem_req", i), 32'(mem_req_o), 32'(tbl[i].ex[5]));
      chk($sformatf("v%0d if_gnt", i), 32'(if_gnt_o), 32'(tbl[i].ex[4]));
      chk($sformatf("v%0d ls_gnt", i), 32'(ls_gnt_o), 32'(tbl[i].ex[3]));
      chk($sformatf("v%0d if_rvalid", i), 32'(if_rvalid_o), 32'(tbl[i].ex[2]));
      chk($sformatf("v%0d ls_rvalid", i), 32'(ls_rvalid_o), 32'(tbl[i].ex[1]));
      chk($sformatf("v%0d if_rdata", i), if_rdata_o, tbl[i].ex[2] ? tbl[i].rd : 32'h0);
      chk($sformatf("v%0d ls_rdata", i), ls_rdata_o, tbl[i].ex[1] ? tbl[i].rd : 32'h0);
      if (tbl[i].ex[5]) begin
        chk($sformatf("v%0d mem_addr", i), mem_addr_o, exp_ls ? 32'h2000 : 32'h100);
        chk($sformatf("v%0d mem_be", i), 32'(mem_be_o), exp_ls ? 32'h3 : 32'hF);
        chk($sformatf("v%0d mem_we", i), 32'(mem_we_o), exp_ls ? 32'(tbl[i].in[3]) : 32'h0);
        chk($sformatf("v%0d mem_wdata", i), mem_wdata_o, exp_ls ? 32'hDEAD_BEEF : 32'h0);
      end
      @(negedge clk_i);
    end

    // ---------------- starvation: both ports always requesting ----------------
    do_reset();
    for (int a = 0; a < 10; a++) begin
      drive(6'b110100, 32'h0);
      #1;
      chk($sformatf("starve arb%0d if_gnt", a), 32'(if_gnt_o), (a == 4 || a == 9) ? 32'h1 : 32'h0);
      chk($sformatf("starve arb%0d ls_gnt", a), 32'(ls_gnt_o), (a == 4 || a == 9) ? 32'h0 : 32'h1);
      @(negedge clk_i);
      drive(6'b110000, 32'h0);
      @(negedge clk_i);
      drive(6'b110010, 32'h1000 + 32'(a));
      #1;
      chk($sformatf("starve arb%0d rsp", a), 32'({if_rvalid_o, ls_rvalid_o}),
          (a == 4 || a == 9) ? 32'h2 : 32'h1);
      @(negedge clk_i);
    end

    // ---------------- flush cases ----------------
    do_reset();
    drive(6'b100100, 32'h0);          // fetch granted
    #1 chk("flush1 gnt", 32'(if_gnt_o), 32'h1);
    @(negedge clk_i);
    drive(6'b100001, 32'h0);          // flush one cycle before rvalid
    @(negedge clk_i);
    drive(6'b100010, 32'hBAD0_BAD0);  // response must be dropped
    #1 chk("flush1 if_rvalid", 32'(if_rvalid_o), 32'h0);
    chk("flush1 if_rdata", if_rdata_o, 32'h0);
    @(negedge clk_i);
    drive(6'b100100, 32'h0);          // next fetch returns normally
    #1 chk("flush1 next gnt", 32'(if_gnt_o), 32'h1);
    @(negedge clk_i);
    drive(6'b100000, 32'h0);
    @(negedge clk_i);
    drive(6'b100010, 32'h13);
    #1 chk("flush1 next rvalid", 32'(if_rvalid_o), 32'h1);
    chk("flush1 next rdata", if_rdata_o, 32'h13);
    @(negedge clk_i);
    drive(6'b100101, 32'h0);          // flush together with the grant
    #1 chk("flush2 gnt", 32'(if_gnt_o), 32'h1);
    @(negedge clk_i);
    drive(6'b100010, 32'h44);
    #1 chk("flush2 if_rvalid", 32'(if_rvalid_o), 32'h0);
    @(negedge clk_i);
    drive(6'b100100, 32'h0);
    @(negedge clk_i);
    drive(6'b100011, 32'h55);         // flush in the response cycle
    #1 chk("flush3 if_rvalid", 32'(if_rvalid_o), 32'h0);
    @(negedge clk_i);
    drive(6'b010100, 32'h0);          // flush must not touch load/store
    @(negedge clk_i);
    drive(6'b010001, 32'h0);
    @(negedge clk_i);
    drive(6'b010011, 32'h66);
    #1 chk("flush ls rvalid", 32'(ls_rvalid_o), 32'h1);
    chk("flush ls rdata", ls_rdata_o, 32'h66);
    @(negedge clk_i);

    // ---------------- reset mid-transaction ----------------
    drive(6'b100100, 32'h0);
    #1 chk("rstmid gnt", 32'(if_gnt_o), 32'h1);
    @(negedge clk_i);
    drive(6'b100000, 32'h0);
    rst_i = 1'b0;
    #1 chk_all_zero("rstmid hold");
    @(negedge clk_i);
    drive(6'b000000, 32'h0);
    rst_i = 1'b1;
    @(negedge clk_i);
    drive(6'b000010, 32'h88);         // late response after release
    #1 chk("rstmid late rvalid", 32'({if_rvalid_o, ls_rvalid_o}), 32'h0);
    @(negedge clk_i);
    drive(6'b100100, 32'h0);          // IDLE: arbitrates immediately
    #1 chk("rstmid idle req", 32'(mem_req_o), 32'h1);
    chk("rstmid idle gnt", 32'(if_gnt_o), 32'h1);
    @(negedge clk_i);
    drive(6'b000010, 32'h0);
    @(negedge clk_i);

    // ---------------- randomized run against a transaction-level model ----------------
    do_reset();
    begin
      bit busy = 0, own_fetch = 0, drop = 0;
      int losses = 0;
      for (int c = 0; c < 3000; c++) begin
        bit pick_if, e_req, e_ifg, e_lsg, e_ifv, e_lsv;
        if_req_i     = ($urandom_range(99) < 70);
        ls_req_i     = ($urandom_range(99) < 60);
        ls_we_i      = $urandom_range(1);
        mem_gnt_i    = ($urandom_range(99) < 60);
        mem_rvalid_i = busy ? ($urandom_range(99) < 50) : ($urandom_range(99) < 10);
        flush_i      = ($urandom_range(99) < 15);
        mem_rdata_i  = $urandom;
        if_addr_i    = $urandom;
        ls_addr_i    = $urandom;
        ls_be_i      = 4'($urandom);
        ls_wdata_i   = $urandom;
        #1;
        pick_if = if_req_i && (!ls_req_i || losses == LIMIT);
        e_req   = !busy && (if_req_i || ls_req_i);
        e_ifg   = e_req && mem_gnt_i && pick_if;
        e_lsg   = e_req && mem_gnt_i && !pick_if;
        e_ifv   = busy && own_fetch && mem_rvalid_i && !drop && !flush_i;
        e_lsv   = busy && !own_fetch && mem_rvalid_i;
        chk($sformatf("rnd%0d mem_req", c), 32'(mem_req_o), 32'(e_req));
        chk($sformatf("rnd%0d gnts", c), 32'({if_gnt_o, ls_gnt_o}), 32'({e_ifg, e_lsg}));
        chk($sformatf("rnd%0d rvalids", c), 32'({if_rvalid_o, ls_rvalid_o}), 32'({e_ifv, e_lsv}));
        chk($sformatf("rnd%0d if_rdata", c), if_rdata_o, e_ifv ? mem_rdata_i : 32'h0);
        chk($sformatf("rnd%0d ls_rdata", c), ls_rdata_o, e_lsv ? mem_rdata_i : 32'h0);
        if (e_req) begin
          chk($sformatf("rnd%0d mem_addr", c), mem_addr_o, pick_if ? if_addr_i : ls_addr_i);
          chk($sformatf("rnd%0d mem_ctl", c), 32'({mem_we_o, mem_be_o}),
              pick_if ? 32'h0F : 32'({ls_we_i, ls_be_i}));
          chk($sformatf("rnd%0d mem_wdata", c), mem_wdata_o, pick_if ? 32'h0 : ls_wdata_i);
        end
        if (e_ifg) losses = 0;
        else if (if_req_i && e_lsg && losses < LIMIT) losses++;
        if (e_ifg || e_lsg) begin
          busy      = 1;
          own_fetch = e_ifg;
          drop      = e_ifg && flush_i;
        end else if (busy && mem_rvalid_i) begin
          busy = 0;
          drop = 0;
        end else if (busy && own_fetch && flush_i) begin
          drop = 1;
        end
        @(negedge clk_i);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive lost arbitrations after which the fetch port wins.
REQ-002 SHALL have ports clk_i (in, 1, sole clock) and rst_i (in, 1, asynchronous active-low reset).
REQ-003 SHALL have if_req_i (in, 1), if_addr_i (in, 32), if_gnt_o (out, 1), if_rvalid_o (out, 1) and if_rdata_o (out, 32): the fetch read port.
REQ-004 SHALL have ls_req_i (in, 1), ls_we_i (in, 1), ls_be_i (in, 4), ls_addr_i (in, 32) and ls_wdata_i (in, 32): the load/store request port.
REQ-005 SHALL have ls_gnt_o (out, 1), ls_rvalid_o (out, 1) and ls_rdata_o (out, 32): the load/store response port.
REQ-006 SHALL have flush_i (in, 1), a branch-taken flush that discards any in-flight fetch response.
REQ-007 SHALL have mem_req_o (out, 1), mem_we_o (out, 1), mem_be_o (out, 4), mem_addr_o (out, 32) and mem_wdata_o (out, 32): the shared memory request.
REQ-008 SHALL have mem_gnt_i (in, 1), mem_rvalid_i (in, 1) and mem_rdata_i (in, 32): the shared memory grant and response.

Function
REQ-009 SHALL implement FSM states IDLE and WAIT_RSP, with at most one outstanding memory transaction.
REQ-010 In IDLE, mem_req_o SHALL equal (if_req_i | ls_req_i), and request fields SHALL be muxed combinationally from the selected port.
REQ-011 Selection SHALL favour the load/store port when both ports request, unless starve_cnt == STARVE_LIMIT, in which case the fetch port is selected.
REQ-012 A fetch request SHALL drive mem_we_o=0, mem_be_o=4'hF and mem_wdata_o=0.
REQ-013 if_gnt_o/ls_gnt_o SHALL equal mem_gnt_i AND (state==IDLE) AND (that port is selected); at most one grant is asserted per cycle.
REQ-014 On grant, the owner SHALL be registered and the FSM SHALL move to WAIT_RSP on the next edge.
REQ-015 In WAIT_RSP, mem_req_o and both grants SHALL be 0, and requests are held off (requesters keep req asserted).
REQ-016 In WAIT_RSP, mem_rvalid_i SHALL be routed as the owner's rvalid, and mem_rdata_i as the owner's rdata, in the same cycle (combinational).
REQ-017 The FSM SHALL return to IDLE on the edge after mem_rvalid_i, giving 1 idle-to-idle bubble minimum; latency is grant + memory latency + 0.
REQ-018 A write SHALL also complete on mem_rvalid_i, with ls_rvalid_o=1 as a write acknowledgement.
REQ-019 starve_cnt (width clog2(STARVE_LIMIT+1)) SHALL increment, saturating at STARVE_LIMIT, when if_req_i=1 and ls_gnt_o=1 in the same cycle.
REQ-020 starve_cnt SHALL clear to 0 on if_gnt_o=1; otherwise it holds.
REQ-021 flush_i=1 while the owner is fetch in WAIT_RSP, or in IDLE together with if_gnt_o, SHALL set drop_flag.
REQ-022 While drop_flag=1, the matching mem_rvalid_i SHALL be consumed with if_rvalid_o forced to 0; drop_flag clears on that response.
REQ-023 flush_i SHALL NOT affect load/store transactions or the grant decision.
REQ-024 flush_i and mem_rvalid_i in the same cycle for a fetch owner SHALL suppress if_rvalid_o in that cycle.
REQ-025 rdata outputs SHALL be 0 whenever the corresponding rvalid is 0.
REQ-026 mem_rvalid_i in IDLE (spurious) SHALL be ignored, with no rvalid output asserted.

Reset
REQ-027 rst_i=0 SHALL asynchronously force state=IDLE, owner=fetch, starve_cnt=0 and drop_flag=0.
REQ-028 During reset, all outputs SHALL be 0.
REQ-029 Reset asserted mid-transaction SHALL abandon the transaction; no rvalid is produced after release.
REQ-030 After release, the first cycle SHALL arbitrate normally.

Structure
REQ-031 Shared package mem_arb_pkg SHALL hold the arb_state_t enum (IDLE, WAIT_RSP), the arb_owner_t enum (OWN_IF, OWN_LS) and the default STARVE_LIMIT constant.
REQ-032 The block SHALL be a single module with no sub-module; the starvation counter, FSM and muxes are local.

Verification
REQ-033 Fetch only, addr 0x100, gnt same cycle, rvalid 2 cycles later with data 0x00000013 -> if_rvalid_o=1 and if_rdata_o=0x00000013 in that cycle, and no ls_* activity.
REQ-034 Both ports requesting every cycle with STARVE_LIMIT=4 -> ls granted 4 times, then if granted on the 5th arbitration, and starve_cnt returns to 0.
REQ-035 ls write, addr 0x2000, be=4'b0011, wdata 0xDEADBEEF -> mem_we_o=1 and mem_be_o=0011 at grant, and ls_rvalid_o=1 on the ack.
REQ-036 Fetch in flight with flush_i pulsed one cycle before rvalid -> if_rvalid_o stays 0, and the next fetch returns normally.
REQ-037 rst_i low during WAIT_RSP, then a late mem_rvalid_i after release -> no rvalid output, and state=IDLE.
REQ-038 mem_gnt_i held 0 for 3 cycles with both requests -> mem_req_o stays 1 with stable ls fields, and no grant outputs.
